// File: rtl/spram_pkg.sv
// ----------------------------------------------------------------------------
// spram_pkg : shared FSM encoding and read-latency limits for spram_burst_ctrl
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int c_RD_LAT_MIN = 1;
  localparam int c_RD_LAT_MAX = 2;

endpackage

`default_nettype wire

// File: rtl/spram_core.sv
// ----------------------------------------------------------------------------
// spram_core : single-port array, sync write, sync read, optional 2nd out reg
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q1;

  // The array itself is never reset so a mid-burst reset leaves contents intact.
  always_ff @(posedge clock) begin
    if (we) r_mem[addr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset_n) r_q1 <= '0;
    else         r_q1 <= r_mem[addr];
  end

  generate
    if (RD_LAT >= 2) begin : g_lat2
      logic [DATA_W-1:0] r_q2;
      always_ff @(posedge clock) begin
        if (reset_n) r_q2 <= '0;
        else         r_q2 <= r_q1;
      end
      assign rdata = r_q2;
    end else begin : g_lat1
      assign rdata = r_q1;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/spram_burst_ctrl.sv
// ----------------------------------------------------------------------------
// spram_burst_ctrl : burst read/write controller over spram_core;
//                    SPRAM_PARITY_EN adds an even-parity bit per word.
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spram_burst_ctrl
  import spram_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              parity_err
);

  localparam int c_LAT = (RD_LAT > c_RD_LAT_MAX) ? c_RD_LAT_MAX :
                         (RD_LAT < c_RD_LAT_MIN) ? c_RD_LAT_MIN : RD_LAT;
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = 1;

`ifdef SPRAM_PARITY_EN
  localparam int c_MEM_W = WIDTH + 1;
  logic [c_MEM_W-1:0] w_wdata;
  assign w_wdata = {^in_data, in_data};
`else
  localparam int c_MEM_W = WIDTH;
  logic [c_MEM_W-1:0] w_wdata;
  assign w_wdata = in_data;
`endif

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_addr, r_rem;
  logic               r_wr_done, r_err;
  logic [c_LAT-1:0]   r_vld, r_lastp;
  logic               w_we, w_issue, w_last, w_rd_done;
  logic [c_MEM_W-1:0] w_rdata;

  assign w_last    = (r_rem == '0);
  assign w_rd_done = r_vld[c_LAT-1] & r_lastp[c_LAT-1];

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_issue = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = mode ? ST_READ : ST_WRITE;
      ST_WRITE: begin
        w_we = in_valid;
        if (in_valid && w_last) w_next = ST_IDLE;
      end
      ST_READ: begin
        w_issue = 1'b1;
        if (w_last) w_next = ST_FLUSH;
      end
      ST_FLUSH: if (w_rd_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_wr_done <= 1'b0;
      r_err     <= 1'b0;
      r_vld     <= '0;
      r_lastp   <= '0;
    end else begin
      r_state    <= w_next;
      r_wr_done  <= w_we & w_last;
      r_err      <= start & (r_state != ST_IDLE);
      r_vld[0]   <= w_issue;
      r_lastp[0] <= w_issue & w_last;
      for (int i = 1; i < c_LAT; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_lastp[i] <= r_lastp[i-1];
      end
      if (r_state == ST_IDLE && start) begin
        r_addr <= base_addr;
        r_rem  <= len;
      end else if (w_we || w_issue) begin
        r_addr <= r_addr + c_ADDR_ONE;
        r_rem  <= r_rem - c_ADDR_ONE;
      end
    end
  end

  spram_core #(
    .DATA_W (c_MEM_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (c_LAT)
  ) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (w_we & ~reset_n),
    .addr    (r_addr),
    .wdata   (w_wdata),
    .rdata   (w_rdata)
  );

  // Outputs are masked during the reset cycle itself, not only after it.
  assign in_ready  = (r_state == ST_WRITE) & ~reset_n;
  assign busy      = (r_state != ST_IDLE) & ~reset_n;
  assign out_valid = r_vld[c_LAT-1] & ~reset_n;
  assign out_data  = reset_n ? '0 : w_rdata[WIDTH-1:0];
  assign done      = (r_wr_done | w_rd_done) & ~reset_n;
  assign err       = r_err & ~reset_n;

`ifdef SPRAM_PARITY_EN
  assign parity_err = out_valid & (^w_rdata);
`else
  assign parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spram_burst_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spram_burst_ctrl : drives RD_LAT=1 and RD_LAT=2 instances in lockstep
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spram_burst_ctrl;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0, len = '0;
  logic [WIDTH-1:0]  in_data = '0;

  logic [1:0] in_ready, out_valid, busy, done, err, parity_err;
  logic [1:0][WIDTH-1:0] out_data;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] model_mem [DEPTH];
  bit corrupt [DEPTH];

  always #5 clock = ~clock;

  spram_burst_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .RD_LAT(1)) dut_l1 (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .base_addr(base_addr), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .parity_err(parity_err[0])
  );

  spram_burst_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .RD_LAT(2)) dut_l2 (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .base_addr(base_addr), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .parity_err(parity_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_perr"}, parity_err, 0);
  endtask

  // data0 < 0 selects random write data, otherwise beat n carries data0+n
  task automatic do_write(input int base, input int ln, input int data0, input int collide_at);
    int  n = 0;
    int  c = 1;
    bit  err_due = 0;
    start = 1; mode = 0; base_addr = base[ADDR_W-1:0]; len = ln[ADDR_W-1:0];
    in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
    @(negedge clock);
    chk("wr_start_busy", busy, 0);
    chk("wr_start_ready", in_ready, 0);
    next_cycle();
    while (n <= ln && c < 200) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = (data0 < 0) ? 8'($urandom) : 8'(data0 + n);
      start     = (c == collide_at);
      mode      = 1'($urandom_range(0, 1));
      base_addr = 4'($urandom);
      len       = 4'($urandom);
      @(negedge clock);
      chk("wr_ready", in_ready, 2'b11);
      chk("wr_busy", busy, 2'b11);
      chk("wr_done_early", done, 0);
      chk("wr_err", err, err_due ? 2'b11 : 2'b00);
      err_due = start;
      if (in_valid) begin
        model_mem[(base + n) % DEPTH] = in_data;
        corrupt[(base + n) % DEPTH]   = 0;
        n++;
      end
      next_cycle();
      c++;
    end
    start = 0; in_valid = 0;
    chk("wr_beats", n, ln + 1);
    @(negedge clock);
    chk("wr_done", done, 2'b11);
    chk("wr_end_busy", busy, 0);
    chk("wr_end_ready", in_ready, 0);
    chk("wr_end_err", err, err_due ? 2'b11 : 2'b00);
    next_cycle();
  endtask

  task automatic do_read(input int base, input int ln);
    int lat, i, a;
    start = 1; mode = 1; base_addr = base[ADDR_W-1:0]; len = ln[ADDR_W-1:0];
    in_valid = 1; in_data = 8'($urandom);
    @(negedge clock);
    chk("rd_start_busy", busy, 0);
    chk("rd_start_valid", out_valid, 0);
    next_cycle();
    start = 0;
    for (int c = 1; c <= ln + 4; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        lat = k + 1;
        i   = c - 1 - lat;
        chk("rd_valid", out_valid[k], (i >= 0 && i <= ln));
        if (i >= 0 && i <= ln) begin
          a = (base + i) % DEPTH;
          chk("rd_data", out_data[k], model_mem[a]);
          chk("rd_perr", parity_err[k], corrupt[a]);
        end else begin
          chk("rd_perr_idle", parity_err[k], 0);
        end
        chk("rd_done", done[k], (c == 1 + ln + lat));
        chk("rd_busy", busy[k], (c <= 1 + ln + lat));
      end
      chk("rd_ready", in_ready, 0);
      chk("rd_err", err, 0);
      next_cycle();
    end
    in_valid = 0;
  endtask

  initial begin
    int a;
    for (int j = 0; j < DEPTH; j++) corrupt[j] = 0;

    // reset state
    reset_n = 1;
    #1;
    @(negedge clock);
    check_quiet("rst0");
    chk("rst0_data0", out_data[0], 0);
    chk("rst0_data1", out_data[1], 0);
    next_cycle();
    @(negedge clock);
    check_quiet("rst1");
    next_cycle();
    reset_n = 0;
    @(negedge clock);
    check_quiet("post_rst");
    chk("post_rst_data", out_data, 0);
    next_cycle();

    // fill the whole array so every later read has a known value
    do_write(0, 15, -1, -1);
    do_read(0, 15);

    // directed write/read with 0xA1..0xA4
    do_write(2, 3, 'hA1, -1);
    do_read(2, 3);

    // wrap-around
    do_write(14, 3, -1, -1);
    do_read(14, 3);
    do_read(15, 2);

    // single-beat read
    do_read(0, 0);

    // start while busy
    do_write(7, 4, -1, 2);
    do_read(7, 4);

    // reset in the second READ cycle
    start = 1; mode = 1; base_addr = 0; len = 3;
    next_cycle();
    start = 0;
    next_cycle();
    reset_n = 1;
    @(negedge clock);
    check_quiet("rst_rd_a");
    next_cycle();
    reset_n = 0;
    @(negedge clock);
    check_quiet("rst_rd_b");
    next_cycle();
    @(negedge clock);
    check_quiet("rst_rd_c");
    next_cycle();
    do_read(0, 15);

    // reset in the second WRITE cycle: beat in that cycle is not accepted
    start = 1; mode = 0; base_addr = 5; len = 3;
    next_cycle();
    start = 0; in_valid = 1; in_data = 8'h3C;
    @(negedge clock);
    chk("rst_wr_ready", in_ready, 2'b11);
    model_mem[5] = 8'h3C;
    next_cycle();
    reset_n = 1; in_data = 8'hC3;
    @(negedge clock);
    check_quiet("rst_wr_a");
    next_cycle();
    reset_n = 0; in_valid = 0;
    @(negedge clock);
    check_quiet("rst_wr_b");
    next_cycle();
    do_read(4, 4);

    // randomized bursts
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), -1, -1);
      else
        do_read(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

`ifdef SPRAM_PARITY_EN
    // flip only the stored parity bit so data is unchanged but parity mismatches
    a = 9;
    dut_l1.u_core.r_mem[a][WIDTH] = ~dut_l1.u_core.r_mem[a][WIDTH];
    dut_l2.u_core.r_mem[a][WIDTH] = ~dut_l2.u_core.r_mem[a][WIDTH];
    corrupt[a] = 1;
    do_read(7, 4);
    do_write(9, 0, -1, -1);
    do_read(7, 4);
`else
    a = 0;
    do_read(a, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
